// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
// Contents:
//   OCC_EMPTY/OCC_ONE/OCC_TWO : occupancy encodings, also the FSM states
//   NOP_INSTR                 : instruction word callers pack into in_data
//                               when they need to inject an explicit bubble
//   occ_full()                : true when no further entry can be held
package pipe_stage_reg_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic occ_full(input logic [1:0] occ);
    return occ == OCC_TWO;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage slot of the pipeline register: a WIDTH-bit register with
// clear (highest priority), load and hold.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (slot resets to zero)
//   load       : capture d on the next rising edge
//   clr        : zero the slot on the next rising edge (wins over load)
//   d          : value to load
//   q          : current slot contents
module pipe_stage_slot #(
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] slot_d;
  logic [WIDTH-1:0] slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load) begin
      slot_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, global
// enable, synchronous flush (bubble insertion) and an optional 2-entry skid
// buffer that makes in_ready a registered signal.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   en                    : global enable, 0 freezes the stage
//   flush_in              : synchronous flush, discards every held entry
//   in_valid/in_ready     : upstream handshake
//   in_ctrl/in_data       : upstream control bits and payload
//   out_valid/out_ready   : downstream handshake
//   out_ctrl/out_data     : main slot contents (zero when empty)
//   occupancy             : held entries, 0..2 (0..1 when SKID=0)
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  localparam int W = DATA_WIDTH + CTRL_WIDTH;

  logic [1:0]   occ_d, occ_q;
  logic         rdy_d, rdy_q;
  logic         in_xfer, out_xfer;
  logic         main_load, main_clr, main_from_skid;
  logic         skid_load, skid_clr;
  logic [W-1:0] main_in, main_q, skid_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Occupancy FSM and slot control. With en=0 both handshakes are masked,
  // so no transfer happens and every branch below falls through to hold.
  always_comb begin
    occ_d          = occ_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush_in) begin
      occ_d    = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (in_xfer) begin
            occ_d     = OCC_ONE;
            main_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            // Downstream stalled in the cycle we still advertised ready:
            // park the new entry behind the one being presented.
            occ_d     = OCC_TWO;
            skid_load = 1'b1;
          end else if (out_xfer) begin
            occ_d    = OCC_EMPTY;
            main_clr = 1'b1;
          end
        end
        OCC_TWO: begin
          if (out_xfer) begin
            occ_d          = OCC_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
    rdy_d = !occ_full(occ_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign main_in = main_from_skid ? skid_q : {in_ctrl, in_data};

  pipe_stage_slot #(.WIDTH(W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clr   (main_clr),
    .d     (main_in),
    .q     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_stage_slot #(.WIDTH(W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clr   (skid_clr),
        .d     ({in_ctrl, in_data}),
        .q     (skid_q)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= rdy_d;
        end
      end

      assign in_ready = en & ~flush_in & rdy_q;
    end else begin : g_no_skid
      logic unused_skid_ctl;
      assign unused_skid_ctl = ^{skid_load, skid_clr, rdy_d};
      assign skid_q   = '0;
      assign rdy_q    = 1'b1;
      // Single entry: accept only if empty or the held entry leaves now.
      assign in_ready = en & ~flush_in & ((occ_q == OCC_EMPTY) | out_ready);
    end
  endgenerate

  assign out_valid = en & (occ_q != OCC_EMPTY);
  assign {out_ctrl, out_data} = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int W  = DW + CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic flush_in = 1'b0;

  logic a_iv, a_ir, a_ov, a_or;
  logic [CW-1:0] a_ic, a_oc;
  logic [DW-1:0] a_id, a_od;
  logic [1:0] a_occ;
  logic b_iv, b_ir, b_ov, b_or;
  logic [CW-1:0] b_ic, b_oc;
  logic [DW-1:0] b_id, b_od;
  logic [1:0] b_occ;

  pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .flush_in(flush_in),
    .in_valid(a_iv), .in_ready(a_ir), .in_ctrl(a_ic), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_ctrl(a_oc), .out_data(a_od),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .flush_in(flush_in),
    .in_valid(b_iv), .in_ready(b_ir), .in_ctrl(b_ic), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_ctrl(b_oc), .out_data(b_od),
    .occupancy(b_occ)
  );

  // Reference model: each stage is a FIFO of entries, capacity 2 (skid) or 1.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] got_a[$];
  int  npass = 0;
  int  nfail = 0;
  int  nchk  = 0;
  bit  acc_a = 1'b0;
  bit  acc_b = 1'b0;
  int  max_occ_a = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic ea_rdy, ea_vld, eb_rdy, eb_vld;
    logic [W-1:0] ea_out, eb_out;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end
    #1;
    ea_rdy = en & !flush_in & (qa.size() < 2);
    ea_vld = en & (qa.size() != 0);
    ea_out = (qa.size() != 0) ? qa[0] : '0;
    eb_rdy = en & !flush_in & ((qb.size() == 0) | b_or);
    eb_vld = en & (qb.size() != 0);
    eb_out = (qb.size() != 0) ? qb[0] : '0;
    check("a_in_ready",  W'(a_ir), W'(ea_rdy));
    check("a_out_valid", W'(a_ov), W'(ea_vld));
    check("a_out",       {a_oc, a_od}, ea_out);
    check("a_occupancy", W'(a_occ), W'(qa.size()));
    check("b_in_ready",  W'(b_ir), W'(eb_rdy));
    check("b_out_valid", W'(b_ov), W'(eb_vld));
    check("b_out",       {b_oc, b_od}, eb_out);
    check("b_occupancy", W'(b_occ), W'(qb.size()));
    if (int'(a_occ) > max_occ_a) max_occ_a = int'(a_occ);
    if (a_ov && a_or) got_a.push_back({a_oc, a_od});
    acc_a = a_iv & ea_rdy;
    acc_b = b_iv & eb_rdy;
    @(posedge clk);
    if (!rst_n || flush_in) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ea_vld && a_or) void'(qa.pop_front());
      if (acc_a) qa.push_back({a_ic, a_id});
      if (eb_vld && b_or) void'(qb.pop_front());
      if (acc_b) qb.push_back({b_ic, b_id});
    end
    @(negedge clk);
  endtask

  // Send n entries base..base+n-1 into dut_a, out_ready from pat per cycle,
  // then confirm the delivered sequence end to end.
  task automatic stream_a(input int n, input logic [DW-1:0] base, input logic [31:0] pat);
    int i = 0;
    int cyc = 0;
    got_a.delete();
    max_occ_a = 0;
    while ((i < n || qa.size() != 0) && cyc < 64) begin
      a_or = (cyc < 32) ? pat[cyc] : 1'b1;
      a_iv = (i < n);
      a_id = base + DW'(i);
      a_ic = CW'(i);
      cycle();
      if (acc_a) i++;
      cyc++;
    end
    a_iv = 1'b0;
    check("stream_sent", W'(i), W'(n));
    check("stream_count", W'(got_a.size()), W'(n));
    for (int k = 0; k < n; k++)
      check("stream_order", (k < got_a.size()) ? got_a[k] : '0, {CW'(k), base + DW'(k)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    a_iv = 1'b1; a_id = 64'hDEAD; a_ic = 8'h0; a_or = 1'b1;
    b_iv = 1'b0; b_id = '0; b_ic = '0; b_or = 1'b1;

    // Reset held with an offered entry: nothing may be captured.
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();          // 0xDEAD accepted
    a_iv = 1'b0;
    cycle();          // 0xDEAD presented
    cycle();

    // Streaming, then backpressure for 3 cycles mid-stream.
    stream_a(8, 64'h1, 32'hFFFF_FFFF);
    check("stream_max_occ", W'(max_occ_a), W'(1));
    stream_a(8, 64'h100, 32'hFFFF_FFC7);
    check("bp_max_occ", W'(max_occ_a), W'(2));

    // Flush with two entries held and a third offered.
    a_or = 1'b0; a_iv = 1'b1; a_ic = 8'hA; a_id = 64'hA;
    cycle();
    a_ic = 8'hB; a_id = 64'hB;
    cycle();
    flush_in = 1'b1; a_ic = 8'hC; a_id = 64'hC;
    cycle();
    flush_in = 1'b0; a_iv = 1'b0; a_or = 1'b1;
    cycle();
    cycle();

    // Enable freeze with 0x55 held.
    a_or = 1'b0; a_iv = 1'b1; a_ic = 8'h5; a_id = 64'h55;
    cycle();
    en = 1'b0; a_id = 64'h77;
    repeat (4) cycle();
    en = 1'b1; a_iv = 1'b0;
    cycle();
    a_or = 1'b1;
    cycle();
    cycle();

    // Reset asserted with two entries held.
    a_or = 1'b0; a_iv = 1'b1; a_id = 64'h11;
    cycle();
    a_id = 64'h22;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; a_iv = 1'b0; a_or = 1'b1;
    cycle();

    // Single-entry build: out_ready toggling with continuous input.
    b_iv = 1'b1; b_id = 64'h300; b_ic = 8'h3;
    for (int k = 0; k < 8; k++) begin
      b_or = (k % 2 == 0);
      cycle();
      if (acc_b) b_id = b_id + 64'h1;
    end
    b_iv = 1'b0; b_or = 1'b1;
    cycle();

    // Randomised traffic on both builds.
    for (int c = 0; c < 400; c++) begin
      en       = ($urandom_range(0, 9) != 0);
      flush_in = ($urandom_range(0, 29) == 0);
      a_or     = 1'($urandom_range(0, 1));
      b_or     = 1'($urandom_range(0, 1));
      if (!(a_iv && !acc_a)) begin
        a_iv = 1'($urandom_range(0, 1));
        a_id = {$urandom, $urandom};
        a_ic = CW'($urandom);
      end
      if (!(b_iv && !acc_b)) begin
        b_iv = 1'($urandom_range(0, 1));
        b_id = {$urandom, $urandom};
        b_ic = CW'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
